// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers,
// status/cause field positions, exception codes.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int SR_IM_HI    = 15;

  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC, PRId plus
// exception/interrupt request generation.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h4A4E_5830
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc;
  logic [31:0] epc;

  logic int_req;
  logic exc_req;
  logic wr_sr;
  logic wr_epc;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != '0) & ~exl;
  assign Req     = int_req | exc_req;

  assign wr_sr  = en & ~Req & (CP0Add == REG_SR);
  assign wr_epc = en & ~Req & (CP0Add == REG_EPC);

  assign EPCOut = epc;

  // SR: exception entry sets EXL; eret beats mtc0 on EXL
  always_ff @(posedge clk) begin
    if (reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (Req) begin
      exl <= 1'b1;
    end else begin
      if (wr_sr) begin
        im <= CP0In[SR_IM_HI:SR_IM_LO];
        ie <= CP0In[SR_IE];
      end
      if (EXLClr)
        exl <= 1'b0;
      else if (wr_sr)
        exl <= CP0In[SR_EXL];
    end
  end

  // Cause: IP tracks pins; BD/ExcCode latch on request
  always_ff @(posedge clk) begin
    if (reset) begin
      bd  <= 1'b0;
      ip  <= '0;
      exc <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        bd  <= BDIn;
        exc <= int_req ? 5'(EXC_INT) : ExcCodeIn;
      end
    end
  end

  // EPC: exception capture outranks mtc0
  always_ff @(posedge clk) begin
    if (reset)
      epc <= '0;
    else if (Req)
      epc <= BDIn ? VPC - 32'd4 : VPC;
    else if (wr_epc)
      epc <= CP0In;
  end

  // mfc0 read mux
  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      REG_SR: begin
        CP0Out[SR_IM_HI:SR_IM_LO] = im;
        CP0Out[SR_EXL]            = exl;
        CP0Out[SR_IE]             = ie;
      end
      REG_CAUSE: begin
        CP0Out[CAUSE_BD]                  = bd;
        CP0Out[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        CP0Out[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
      end
      REG_EPC:  CP0Out = epc;
      REG_PRID: CP0Out = PRID_VALUE;
      default:  CP0Out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// CP0 bench: word-level model checked every
// cycle, plus directed literal expectations.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] PRID = 32'h4A4E_5830;

  cp0 dut (
    .clk(clk), .reset(reset), .en(en),
    .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  // model state as whole 32-bit register images
  logic [31:0] m_sr, m_cause, m_epc;
  bit m_valid = 0;

  function automatic bit m_int();
    return ((HWInt & m_sr[15:10]) != 0)
        && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_int() ||
      (ExcCodeIn != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(
    input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit r, ir;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      m_valid = 1;
    end else if (m_valid) begin
      r  = m_req();
      ir = m_int();
      m_cause = (m_cause & ~32'h0000_FC00)
              | (32'(HWInt) << 10);
      if (r) begin
        m_sr = m_sr | 32'h2;
        m_cause = (m_cause & 32'h0000_FC00)
                | (32'(BDIn) << 31)
                | (ir ? 32'h0 : 32'(ExcCodeIn) << 2);
        m_epc = BDIn ? VPC - 4 : VPC;
      end else begin
        if (en && CP0Add == 12)
          m_sr = CP0In & 32'h0000_FC03;
        if (en && CP0Add == 14)
          m_epc = CP0In;
        if (EXLClr)
          m_sr = m_sr & ~32'h2;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid && !reset) begin
      chk("model Req", 32'(Req), 32'(m_req()));
      chk("model EPCOut", EPCOut, m_epc);
      chk("model CP0Out", CP0Out, m_read(CP0Add));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; EXLClr = 0; ExcCodeIn = 0;
    HWInt = 0; BDIn = 0; reset = 0;
  endtask

  task automatic rd(input logic [4:0] a,
                    input string nm,
                    input logic [31:0] exp);
    CP0Add = a;
    #1;
    chk(nm, CP0Out, exp);
  endtask

  initial begin
    reset = 1; en = 0; CP0Add = 0; CP0In = 0;
    VPC = 0; BDIn = 0; ExcCodeIn = 0;
    HWInt = 0; EXLClr = 0;
    step();
    step();
    reset = 0;
    rd(12, "reset SR", 32'h0);
    rd(13, "reset Cause", 32'h0);
    chk("reset EPCOut", EPCOut, 32'h0);
    chk("reset Req", 32'(Req), 32'h0);

    // mtc0 SR
    en = 1; CP0Add = 12; CP0In = 32'h0000_FC01;
    step();
    idle();
    rd(12, "mtc0 SR", 32'h0000_FC01);
    chk("mtc0 Req", 32'(Req), 32'h0);

    // interrupt entry
    HWInt = 6'b000001; VPC = 32'h0000_3010;
    #1;
    chk("int Req", 32'(Req), 32'h1);
    step();
    HWInt = 0;
    chk("int EPC", EPCOut, 32'h0000_3010);
    rd(13, "int Cause", 32'h0000_0400);
    rd(12, "int SR EXL", 32'h0000_FC03);
    chk("int Req masked", 32'(Req), 32'h0);
    EXLClr = 1;
    step();
    idle();
    rd(12, "eret SR", 32'h0000_FC01);

    // overflow in delay slot
    ExcCodeIn = 12; BDIn = 1; VPC = 32'h0000_3008;
    step();
    idle();
    chk("ov EPC", EPCOut, 32'h0000_3004);
    rd(13, "ov Cause", 32'h8000_0030);

    // syscall masked by EXL until eret
    ExcCodeIn = 8;
    #1;
    chk("sys masked Req", 32'(Req), 32'h0);
    EXLClr = 1;
    step();
    EXLClr = 0;
    rd(12, "sys eret SR", 32'h0000_FC01);
    chk("sys Req", 32'(Req), 32'h1);
    VPC = 32'h0000_3020;
    step();
    idle();
    rd(13, "sys Cause", 32'h0000_0020);
    chk("sys EPC", EPCOut, 32'h0000_3020);
    EXLClr = 1;
    step();
    idle();

    // interrupt beats RI
    ExcCodeIn = 10; HWInt = 6'b000010;
    VPC = 32'h0000_3030;
    step();
    idle();
    rd(13, "prio Cause", 32'h0000_0800);
    EXLClr = 1;
    step();
    idle();

    // mtc0 EPC loses to exception
    ExcCodeIn = 5; en = 1; CP0Add = 14;
    CP0In = 32'h0000_5000; VPC = 32'h0000_3000;
    step();
    idle();
    chk("exc vs mtc0 EPC", EPCOut, 32'h0000_3000);
    EXLClr = 1;
    step();
    idle();

    // mtc0 EPC, no bypass
    en = 1; CP0Add = 14; CP0In = 32'h0000_5000;
    #1;
    chk("EPC no bypass", EPCOut, 32'h0000_3000);
    step();
    idle();
    chk("EPC written", EPCOut, 32'h0000_5000);

    // PRId, unmapped, Cause write ignored
    rd(15, "PRId", PRID);
    rd(0, "unmapped 0", 32'h0);
    rd(16, "unmapped 16", 32'h0);
    en = 1; CP0Add = 13; CP0In = 32'hFFFF_FFFF;
    step();
    idle();
    rd(13, "Cause ro", 32'h0000_0014);

    // VPC-4 wrap
    ExcCodeIn = 4; BDIn = 1; VPC = 32'h0;
    step();
    idle();
    chk("wrap EPC", EPCOut, 32'hFFFF_FFFC);
    rd(13, "wrap Cause", 32'h8000_0010);

    // eret beats mtc0 setting EXL
    EXLClr = 1; en = 1; CP0Add = 12;
    CP0In = 32'h0000_FC03;
    step();
    idle();
    rd(12, "eret vs mtc0", 32'h0000_FC01);

    // eret loses to same-cycle request
    EXLClr = 1; ExcCodeIn = 12;
    VPC = 32'h0000_4000;
    step();
    idle();
    rd(12, "eret vs req", 32'h0000_FC03);

    // reset beats req/en/eret
    EXLClr = 1;
    step();
    idle();
    reset = 1; ExcCodeIn = 4; en = 1;
    CP0Add = 14; CP0In = 32'h1234_5678;
    step();
    reset = 0; en = 0;
    rd(12, "rst SR", 32'h0);
    chk("rst EPC", EPCOut, 32'h0);
    chk("rst Req exc", 32'(Req), 32'h1);
    ExcCodeIn = 0;
    #1;
    chk("rst Req idle", 32'(Req), 32'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
